// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  localparam int unsigned DEF_NUM_LINES      = 64;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;

  // Boot vector, used by benches as the first fetch address.
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/icache_refill.sv
// Line-refill FSM: latches the missing line, walks its beats over the memory
// handshake and emits the array write strobes for the top level.
module icache_refill
  import icache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE),
  localparam int unsigned LINE_W = 30 - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss,
  input  logic [LINE_W-1:0] miss_line,
  input  logic              mem_ready,
  output logic              refill_busy,
  output logic              fill_start,
  output logic              data_we,
  output logic [OFF_W-1:0]  data_offset,
  output logic              tag_we,
  output logic [LINE_W-1:0] fill_line,
  output logic              mem_req,
  output logic [31:0]       mem_addr
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_d      = line_q;
    fill_start  = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    refill_busy = (state_q == REFILL);
    mem_req     = 1'b0;
    mem_addr    = '0;
    data_offset = beat_q;
    fill_line   = line_q;

    case (state_q)
      IDLE: begin
        if (miss) begin
          fill_start = 1'b1;
          line_d     = miss_line;
          beat_d     = '0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        // Line base is aligned, so concatenating the beat never carries into the index.
        mem_addr = {line_q, beat_q, 2'b00};
        if (mem_ready) begin
          data_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_we  = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with combinational hit path.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        cache_ready,
  output logic [31:0] instr_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned LINE_W = 30 - OFF_W;
  localparam int unsigned TAG_W  = LINE_W - IDX_W;

  logic [LINE_W-1:0] pc_line;
  logic [OFF_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic              unused_bits;

  assign pc_line     = pc_in[31:OFF_W+2];
  assign pc_off      = pc_in[OFF_W+1:2];
  assign pc_idx      = pc_line[IDX_W-1:0];
  assign pc_tag      = pc_line[LINE_W-1:IDX_W];
  assign unused_bits = ^pc_in[1:0];

  logic              refill_busy, fill_start, data_we, tag_we;
  logic [OFF_W-1:0]  data_offset;
  logic [LINE_W-1:0] fill_line;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit_raw, hit;

  assign fill_idx = fill_line[IDX_W-1:0];
  assign fill_tag = fill_line[LINE_W-1:IDX_W];

  icache_refill #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_refill (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss       (!hit_raw),
    .miss_line  (pc_line),
    .mem_ready  (mem_ready),
    .refill_busy(refill_busy),
    .fill_start (fill_start),
    .data_we    (data_we),
    .data_offset(data_offset),
    .tag_we     (tag_we),
    .fill_line  (fill_line),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr)
  );

  logic [31:0]      data_mem [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  // Data and tags carry no reset; only the valid bits need a defined state.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{fill_idx, data_offset}] <= mem_rdata;
    end
    if (tag_we) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
    always_comb begin
      valid_d[gi] = valid_q[gi];
      if (tag_we && fill_idx == IDX_W'(gi)) begin
        valid_d[gi] = 1'b1;
      end else if (fill_start && pc_idx == IDX_W'(gi)) begin
        valid_d[gi] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Any lookup during a refill is stalled, even one that would hit another line.
  assign hit_raw     = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign hit         = hit_raw && !refill_busy;
  assign cache_ready = hit;
  assign instr_out   = hit ? data_mem[{pc_idx, pc_off}] : 32'h0;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && hit_cnt_q != 32'hFFFF_FFFF) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (fill_start && miss_cnt_q != 32'hFFFF_FFFF) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run
// compared against a line-level valid/tag model and a fixed memory image.
module tb_icache;
  import icache_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        cache_ready;
  logic [31:0] instr_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int miss_exp = 0;

  bit          m_valid [64];
  int unsigned m_tag   [64];

  icache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .cache_ready(cache_ready),
    .instr_out  (instr_out),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: 0xBFC0xxxx maps to 0x1111_0000 + word number, unique per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:16] ^ 16'hAED1, 2'b00, a[15:2]};
  endfunction

  assign mem_rdata = mem_req ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 4) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> 10;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    miss_exp = 0;
  endtask

  task automatic model_fill(input logic [31:0] pc);
    m_valid[idx_of(pc)] = 1'b1;
    m_tag[idx_of(pc)]   = tag_of(pc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at the start of a cycle (just after the rising edge).
  task automatic do_fetch(input logic [31:0] pc, input int mode, input bit redirect, output int lat);
    logic [31:0] base;
    int beat;
    int cyc;
    bit exp_hit;
    lat = 0;
    pc_in = pc;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    exp_hit = m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    checks++;
    if (exp_hit) begin
      if (cache_ready !== 1'b1 || instr_out !== mem_word(pc & ~32'h3) || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL hit pc=%h: ready=%b instr=%h req=%b, expected ready=1 instr=%h req=0",
                 pc, cache_ready, instr_out, mem_req, mem_word(pc & ~32'h3));
      end
      next_cycle();
      return;
    end
    if (cache_ready !== 1'b0 || instr_out !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL miss_detect pc=%h: ready=%b instr=%h req=%b addr=%h, expected 0/0/0/0",
               pc, cache_ready, instr_out, mem_req, mem_addr);
    end
    miss_exp++;
    base = pc & ~32'hF;
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 200) begin
      next_cycle();
      cyc++;
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = (cyc % 4 == 0);
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      pc_in = redirect ? $urandom : pc;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== base + 32'(4 * beat) || cache_ready !== 1'b0 || instr_out !== 32'h0) begin
        errors++;
        $display("FAIL refill_beat pc=%h cyc=%0d: req=%b addr=%h ready=%b instr=%h, expected req=1 addr=%h ready=0 instr=0",
                 pc, cyc, mem_req, mem_addr, cache_ready, instr_out, base + 32'(4 * beat));
      end
      if (mem_ready) beat++;
    end
    if (beat < 4) begin
      errors++;
      $display("FAIL refill_timeout pc=%h: beats=%0d, expected 4", pc, beat);
      return;
    end
    model_fill(pc);
    next_cycle();
    cyc++;
    pc_in = pc;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (cache_ready !== 1'b1 || instr_out !== mem_word(pc & ~32'h3) || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL post_fill_hit pc=%h: ready=%b instr=%h req=%b, expected ready=1 instr=%h req=0",
               pc, cache_ready, instr_out, mem_req, mem_word(pc & ~32'h3));
    end
    lat = cyc;
    next_cycle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc_in = RESET_PC;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cache_ready !== 1'b0 || instr_out !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b instr=%h req=%b addr=%h, expected all 0",
               cache_ready, instr_out, mem_req, mem_addr);
    end
`ifdef ICACHE_PERF_EN
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, expected 0 0", hit_count, miss_count);
    end
`endif
    next_cycle();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_cold_fill();
    int lat;
    do_fetch(RESET_PC, 0, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL cold_fill_latency: got %0d cycles, expected 5", lat);
    end
  endtask

  task automatic test_same_line_hit();
    int lat;
    do_fetch(32'hBFC0_0008, 0, 1'b0, lat);
    @(negedge clk);
    checks++;
    if (lat !== 0 || cache_ready !== 1'b1 || instr_out !== 32'h1111_0002) begin
      errors++;
      $display("FAIL same_line_hit: lat=%0d ready=%b instr=%h, expected lat=0 ready=1 instr=11110002",
               lat, cache_ready, instr_out);
    end
`ifdef ICACHE_PERF_EN
    begin
      logic [31:0] h0;
      h0 = hit_count;
      repeat (6) next_cycle();
      @(negedge clk);
      checks++;
      if (hit_count - h0 !== 32'd6) begin
        errors++;
        $display("FAIL hit_count_delta: got %0d, expected 6", hit_count - h0);
      end
    end
`endif
    next_cycle();
  endtask

  task automatic test_conflict();
    int lat1, lat2;
    do_fetch(32'hBFC0_0400, 0, 1'b0, lat1);
    do_fetch(RESET_PC, 0, 1'b0, lat2);
    checks++;
    if (lat1 !== 5 || lat2 !== 5) begin
      errors++;
      $display("FAIL conflict_eviction: latencies %0d/%0d, expected 5/5", lat1, lat2);
    end
`ifdef ICACHE_PERF_EN
    checks++;
    if (miss_count !== 32'(miss_exp) || miss_exp != 3) begin
      errors++;
      $display("FAIL miss_count: got %0d, expected 3", miss_count);
    end
`endif
  endtask

  task automatic test_slow_memory();
    int lat;
    do_fetch(32'hBFC0_0024, 1, 1'b0, lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL slow_memory_latency: got %0d cycles, expected 17", lat);
    end
  endtask

  task automatic test_redirect();
    int lat;
    apply_reset();
    pc_in = RESET_PC;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cache_ready !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_miss0: ready=%b req=%b, expected 0 0", cache_ready, mem_req);
    end
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      if (c >= 2) pc_in = 32'hBFC0_0010;
      @(negedge clk);
      checks++;
      if (c == 5) begin
        if (cache_ready !== 1'b0 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL redirect_newpc_miss: ready=%b req=%b, expected 0 0", cache_ready, mem_req);
        end
      end else begin
        logic [31:0] exp_addr;
        exp_addr = (c <= 4) ? RESET_PC + 32'(4 * (c - 1)) : 32'hBFC0_0010 + 32'(4 * (c - 6));
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || cache_ready !== 1'b0) begin
          errors++;
          $display("FAIL redirect_beat c=%0d: req=%b addr=%h ready=%b, expected req=1 addr=%h ready=0",
                   c, mem_req, mem_addr, cache_ready, exp_addr);
        end
      end
    end
    model_fill(RESET_PC);
    model_fill(32'hBFC0_0010);
    next_cycle();
    @(negedge clk);
    checks++;
    if (cache_ready !== 1'b1 || instr_out !== mem_word(32'hBFC0_0010)) begin
      errors++;
      $display("FAIL redirect_hit: ready=%b instr=%h, expected 1 %h", cache_ready, instr_out, mem_word(32'hBFC0_0010));
    end
    next_cycle();
    do_fetch(RESET_PC, 0, 1'b0, lat);
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL redirect_line0_kept: latency %0d, expected 0", lat);
    end
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    pc_in = 32'hBFC0_0040;
    mem_ready = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0040 + 32'(4 * (c - 1))) begin
        errors++;
        $display("FAIL pre_reset_beat c=%0d: req=%b addr=%h", c, mem_req, mem_addr);
      end
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || cache_ready !== 1'b0 || instr_out !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_drop: req=%b addr=%h ready=%b instr=%h, expected all 0",
               mem_req, mem_addr, cache_ready, instr_out);
    end
    next_cycle();
    rst_n = 1'b1;
    model_clear();
    do_fetch(32'hBFC0_0040, 0, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL refetch_after_reset: latency %0d, expected 5", lat);
    end
  endtask

  task automatic test_random();
    int unsigned tags [4] = '{32'h2FF00, 32'h2FF01, 32'h00012, 32'h3ABCD};
    int lat;
    logic [31:0] pc;
    for (int n = 0; n < 80; n++) begin
      pc = (tags[$urandom_range(0, 3)] << 10) | ($urandom_range(0, 7) << 4)
         | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      do_fetch(pc, $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pc_in = RESET_PC;
    mem_ready = 1'b0;
    test_reset();
    test_cold_fill();
    test_same_line_hit();
    test_conflict();
    test_slow_memory();
    test_redirect();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
